system_bus_map: RTL and testbench
=================================

SYSTEM_BUS_MAP -- requirements
Module: system_bus_map

Parameters
REQ-001 The block SHALL have parameter NREG, default 3, meaning the number of decoded regions (legal range 1..8).
REQ-002 The block SHALL have parameter REG_START, default {16'hFF80,16'h4400,16'h1C00}, meaning the packed 16-bit base addresses, with region 0 in the LSBs.
REQ-003 The block SHALL have parameter REG_LEN, default {16'h0080,16'hBB80,16'h1000}, meaning the packed 16-bit region lengths in bytes, all nonzero.
REQ-004 The block SHALL have parameter REG_WAIT, default {4'd0,4'd1,4'd0}, meaning the packed 4-bit wait-state counts per region (0..15).
REQ-005 The block SHALL have parameter REG_WP, default 3'b100, meaning the per-region write-protect mask (1 = writes blocked).
REQ-006 The block SHALL have parameter VACANT_VAL, default 16'h3FFF, meaning the read data returned for unmapped addresses.

Interface
REQ-007 MCLK  in  1  system clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 REQ  in  1  CPU access strobe, sampled in IDLE only.
REQ-010 MAB  in  16  memory address bus.
REQ-011 MDBwrite  in  16  write data from the CPU.
REQ-012 MW  in  1  access is a write (1) or a read (0).
REQ-013 BW  in  1  byte access (1) or word access (0).
REQ-014 CLR_FLAGS  in  1  clears the sticky VMAIFG and ACCVIFG flags.
REQ-015 RD_BUS  in  16*NREG  packed read data from the regions, word-aligned, region r at bits [16r+15:16r].
REQ-016 CS  out  NREG  one-hot region select.
REQ-017 WE  out  1  write enable to the selected region.
REQ-018 ADDR_OUT  out  16  latched access address.
REQ-019 WDATA  out  16  latched write data.
REQ-020 BE  out  2  byte enables (bit0 = low byte).
REQ-021 MDBread  out  16  read data to the CPU.
REQ-022 READY  out  1  access complete, one-cycle pulse.
REQ-023 VMAIFG  out  1  sticky vacant-memory-access flag.
REQ-024 ACCVIFG  out  1  sticky write-protect-violation flag.

Function
REQ-025 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE.
REQ-026 In IDLE with REQ=1, the block SHALL latch MAB, MDBwrite, MW and BW, decode the region, and go to ACCESS on the next edge.
REQ-027 Decode SHALL hit region r when START_r <= MAB <= START_r+LEN_r-1, computed in 17 bits so that no wrap occurs at 16'hFFFF.
REQ-028 When regions overlap, the lowest-index region SHALL win.
REQ-029 ACCESS and WAIT SHALL assert CS[r]; the block SHALL stay in WAIT for REG_WAIT[r] cycles using a 4-bit down-counter loaded on entry to ACCESS, and SHALL go ACCESS->DONE directly when the count is 0.
REQ-030 In DONE, the block SHALL pulse READY=1 for one cycle, drive MDBread valid for that cycle, and return to IDLE; CS SHALL be 0 in DONE.
REQ-031 Total latency from the REQ-sampling edge to READY SHALL be 2+REG_WAIT[r] cycles.
REQ-032 The block SHALL ignore REQ outside IDLE, with no queueing.
REQ-033 ADDR_OUT SHALL be the latched address with bit0 forced to 0.
REQ-034 For word access, BE SHALL be 2'b11 and the address LSB SHALL be ignored.
REQ-035 For byte access, BE SHALL be 2'b01 for an even address and 2'b10 for an odd address.
REQ-036 For a byte write, WDATA SHALL carry the byte replicated in both lanes.
REQ-037 For a byte read, MDBread SHALL be the addressed byte zero-extended to 16 bits.
REQ-038 WE SHALL be 1 only in ACCESS and WAIT, only when MW=1, and only when the region is not write-protected.
REQ-039 MDBread SHALL be registered from RD_BUS in the final ACCESS/WAIT cycle and SHALL hold its value until the next DONE.
REQ-040 An unmapped access SHALL assert no CS, skip WAIT, return VACANT_VAL (byte-reduced per REQ-037) on reads, drop writes, and set VMAIFG.
REQ-041 A write to a WP region SHALL complete with normal timing and WE=0, and SHALL set ACCVIFG.
REQ-042 CLR_FLAGS SHALL clear both flags, and a set event in the same cycle SHALL take priority over the clear.

Reset
REQ-043 rst=1 SHALL force IDLE, with CS=0, WE=0, READY=0, BE=0, ADDR_OUT=0, WDATA=0, MDBread=0, VMAIFG=0, ACCVIFG=0, and the counter at 0.
REQ-044 rst asserted mid-access SHALL abort the access with no READY pulse; a REQ held high through rst release SHALL be accepted on the first edge after release.

Verification
REQ-045 Read of word 16'h1C02 with RD_BUS region0=16'hA55A -> CS=001 for 1 cycle, READY 2 cycles after the REQ edge, MDBread=16'hA55A.
REQ-046 Byte read at 16'h4401 with region1 data 16'h12AB and REG_WAIT=1 -> CS=010 for 2 cycles, READY at cycle 3, MDBread=16'h0012.
REQ-047 Byte write of 16'h00CD to 16'h1C05 -> WE=1, BE=2'b10, ADDR_OUT=16'h1C04, WDATA=16'hCDCD.
REQ-048 Write to 16'hFFFE (WP region2) -> WE=0, READY at cycle 2, ACCVIFG=1 until CLR_FLAGS.
REQ-049 Read at 16'h0800 (unmapped) -> CS=0, MDBread=16'h3FFF, VMAIFG=1; a simultaneous CLR_FLAGS leaves VMAIFG=1.
REQ-050 rst pulsed during WAIT -> no READY pulse, all outputs at reset values, and a new REQ is served normally.

Source files
------------

// File: rtl/system_bus_map.sv
// Address decoder and access sequencer between the CPU memory bus and a set of
// mapped regions, with per-region wait states, write protection and sticky error flags.
module system_bus_map #(
  parameter int unsigned        NREG       = 3,
  parameter logic [16*NREG-1:0] REG_START  = {16'hFF80, 16'h4400, 16'h1C00},
  parameter logic [16*NREG-1:0] REG_LEN    = {16'h0080, 16'hBB80, 16'h1000},
  parameter logic [4*NREG-1:0]  REG_WAIT   = {4'd0, 4'd1, 4'd0},
  parameter logic [NREG-1:0]    REG_WP     = 3'b100,
  parameter logic [15:0]        VACANT_VAL = 16'h3FFF
) (
  input  logic               MCLK,
  input  logic               rst,
  input  logic               REQ,
  input  logic [15:0]        MAB,
  input  logic [15:0]        MDBwrite,
  input  logic               MW,
  input  logic               BW,
  input  logic               CLR_FLAGS,
  input  logic [16*NREG-1:0] RD_BUS,
  output logic [NREG-1:0]    CS,
  output logic               WE,
  output logic [15:0]        ADDR_OUT,
  output logic [15:0]        WDATA,
  output logic [1:0]         BE,
  output logic [15:0]        MDBread,
  output logic               READY,
  output logic               VMAIFG,
  output logic               ACCVIFG
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              final_cyc;
  logic [3:0]        cnt_q;
  logic [NREG-1:0]   sel_q;
  logic              mw_q, bw_q, a0_q;

  logic              dec_hit;
  logic [NREG-1:0]   dec_sel;
  logic [3:0]        dec_wait;
  logic [16:0]       lo, hi;

  logic [15:0]       rd_word, src, rd_fmt;
  logic              sel_wp, hit_q, active;

  // 17-bit bounds so a region ending at 16'hFFFF does not wrap to zero
  always_comb begin
    dec_hit  = 1'b0;
    dec_sel  = '0;
    dec_wait = '0;
    lo       = '0;
    hi       = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      lo = {1'b0, REG_START[16*r +: 16]};
      hi = lo + {1'b0, REG_LEN[16*r +: 16]} - 17'd1;
      if (!dec_hit && ({1'b0, MAB} >= lo) && ({1'b0, MAB} <= hi)) begin
        dec_hit    = 1'b1;
        dec_sel[r] = 1'b1;
        dec_wait   = REG_WAIT[4*r +: 4];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    sel_wp  = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (sel_q[r]) begin
        rd_word = RD_BUS[16*r +: 16];
        sel_wp  = REG_WP[r];
      end
    end
  end

  assign hit_q  = |sel_q;
  assign src    = hit_q ? rd_word : VACANT_VAL;
  assign rd_fmt = bw_q ? {8'h00, (a0_q ? src[15:8] : src[7:0])} : src;

  always_comb begin
    state_d   = state_q;
    final_cyc = 1'b0;
    case (state_q)
      IDLE:   if (REQ) state_d = ACCESS;
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          final_cyc = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          final_cyc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      mw_q     <= 1'b0;
      bw_q     <= 1'b0;
      a0_q     <= 1'b0;
      ADDR_OUT <= '0;
      WDATA    <= '0;
      BE       <= '0;
      MDBread  <= '0;
      VMAIFG   <= 1'b0;
      ACCVIFG  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && REQ) begin
        sel_q    <= dec_sel;
        mw_q     <= MW;
        bw_q     <= BW;
        a0_q     <= MAB[0];
        cnt_q    <= dec_hit ? dec_wait : 4'd0;
        ADDR_OUT <= {MAB[15:1], 1'b0};
        BE       <= BW ? (MAB[0] ? 2'b10 : 2'b01) : 2'b11;
        WDATA    <= BW ? {2{MDBwrite[7:0]}} : MDBwrite;
      end
      // counter is pre-decremented on leaving ACCESS so WAIT ends on zero
      if ((state_q == ACCESS || state_q == WAIT) && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      if (final_cyc)
        MDBread <= rd_fmt;
      VMAIFG  <= (final_cyc && !hit_q) || (VMAIFG && !CLR_FLAGS);
      ACCVIFG <= (final_cyc && hit_q && mw_q && sel_wp) || (ACCVIFG && !CLR_FLAGS);
    end
  end

  assign active = (state_q == ACCESS) || (state_q == WAIT);
  assign CS     = active ? sel_q : '0;
  assign WE     = active && mw_q && hit_q && !sel_wp;
  assign READY  = (state_q == DONE);

endmodule

// File: tb/tb_system_bus_map.sv
// Randomized bench for system_bus_map against a table-driven address-map model.
module tb_system_bus_map;

  logic        MCLK = 1'b0;
  logic        rst, REQ, MW, BW, CLR_FLAGS;
  logic [15:0] MAB, MDBwrite;
  logic [47:0] RD_BUS;
  logic [2:0]  CS;
  logic        WE, READY, VMAIFG, ACCVIFG;
  logic [15:0] ADDR_OUT, WDATA, MDBread;
  logic [1:0]  BE;

  int n_chk  = 0;
  int n_pass = 0;

  int st [3] = '{'h1C00, 'h4400, 'hFF80};
  int ln [3] = '{'h1000, 'hBB80, 'h0080};
  int wt [3] = '{0, 1, 0};
  int wp [3] = '{0, 0, 1};
  logic vma_m = 1'b0;
  logic acc_m = 1'b0;

  always #5 MCLK = ~MCLK;

  system_bus_map #(
    .NREG(3),
    .REG_START({16'hFF80, 16'h4400, 16'h1C00}),
    .REG_LEN({16'h0080, 16'hBB80, 16'h1000}),
    .REG_WAIT({4'd0, 4'd1, 4'd0}),
    .REG_WP(3'b100),
    .VACANT_VAL(16'h3FFF)
  ) dut (
    .MCLK(MCLK), .rst(rst), .REQ(REQ), .MAB(MAB), .MDBwrite(MDBwrite),
    .MW(MW), .BW(BW), .CLR_FLAGS(CLR_FLAGS), .RD_BUS(RD_BUS),
    .CS(CS), .WE(WE), .ADDR_OUT(ADDR_OUT), .WDATA(WDATA), .BE(BE),
    .MDBread(MDBread), .READY(READY), .VMAIFG(VMAIFG), .ACCVIFG(ACCVIFG)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int region(input int a);
    for (int i = 0; i < 3; i++)
      if (a >= st[i] && a <= st[i] + ln[i] - 1) return i;
    return -1;
  endfunction

  task automatic issue(input logic [15:0] a, input logic mw, input logic bw,
                       input logic [15:0] wd, input logic [47:0] rb, input logic clr);
    REQ = 1'b1; MAB = a; MW = mw; BW = bw; MDBwrite = wd; RD_BUS = rb; CLR_FLAGS = clr;
  endtask

  // Starts at the edge that samples REQ; ends at a negedge in IDLE.
  task automatic serve(input logic [15:0] a, input logic mw, input logic bw,
                       input logic [15:0] wd, input logic [47:0] rb, input logic clr);
    int r, w, lat;
    logic [15:0] srcw, emdb;
    r = region(int'(a));
    w = (r >= 0) ? wt[r] : 0;
    lat = 2 + w;
    srcw = (r >= 0) ? rb[16*r +: 16] : 16'h3FFF;
    emdb = bw ? (a[0] ? {8'h00, srcw[15:8]} : {8'h00, srcw[7:0]}) : srcw;
    @(posedge MCLK);
    if (clr) begin vma_m = 1'b0; acc_m = 1'b0; end
    #1;
    REQ = 1'($urandom_range(0, 1));
    MAB = 16'($urandom); MDBwrite = 16'($urandom);
    MW = 1'($urandom_range(0, 1)); BW = 1'($urandom_range(0, 1));
    for (int c = 1; c <= lat; c++) begin
      @(negedge MCLK);
      if (c >= 2 && clr) begin vma_m = 1'b0; acc_m = 1'b0; end
      if (c == lat) begin
        if (r < 0) vma_m = 1'b1;
        else if (mw && wp[r] != 0) acc_m = 1'b1;
      end
      chk("cs", 32'(CS), (c < lat && r >= 0) ? (32'd1 << r) : 32'd0);
      chk("we", 32'(WE), 32'(c < lat && mw && r >= 0 && wp[r] == 0));
      chk("ready", 32'(READY), 32'(c == lat));
      if (c == 1) begin
        chk("addr_out", 32'(ADDR_OUT), 32'(a & 16'hFFFE));
        chk("be", 32'(BE), bw ? (a[0] ? 32'd2 : 32'd1) : 32'd3);
        chk("wdata", 32'(WDATA), bw ? 32'({wd[7:0], wd[7:0]}) : 32'(wd));
      end
      if (c == lat) begin
        chk("mdbread", 32'(MDBread), 32'(emdb));
        chk("vmaifg", 32'(VMAIFG), 32'(vma_m));
        chk("accvifg", 32'(ACCVIFG), 32'(acc_m));
        REQ = 1'b0;
      end
    end
    @(negedge MCLK);
    if (clr) begin vma_m = 1'b0; acc_m = 1'b0; end
    chk("idle_ready", 32'(READY), 32'd0);
    chk("idle_cs", 32'(CS), 32'd0);
    chk("idle_vma", 32'(VMAIFG), 32'(vma_m));
    chk("idle_accv", 32'(ACCVIFG), 32'(acc_m));
    CLR_FLAGS = 1'b0;
  endtask

  task automatic xact(input logic [15:0] a, input logic mw, input logic bw,
                      input logic [15:0] wd, input logic [47:0] rb, input logic clr);
    issue(a, mw, bw, wd, rb, clr);
    serve(a, mw, bw, wd, rb, clr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"}, 32'(CS), 32'd0);
    chk({tag, "_we"}, 32'(WE), 32'd0);
    chk({tag, "_ready"}, 32'(READY), 32'd0);
    chk({tag, "_be"}, 32'(BE), 32'd0);
    chk({tag, "_addr"}, 32'(ADDR_OUT), 32'd0);
    chk({tag, "_wdata"}, 32'(WDATA), 32'd0);
    chk({tag, "_mdb"}, 32'(MDBread), 32'd0);
    chk({tag, "_vma"}, 32'(VMAIFG), 32'd0);
    chk({tag, "_accv"}, 32'(ACCVIFG), 32'd0);
  endtask

  function automatic logic [15:0] pick_addr();
    int k, b;
    k = int'($urandom_range(0, 2));
    case ($urandom_range(0, 5))
      0: b = st[k] - 1;
      1: b = st[k];
      2: b = st[k] + ln[k] - 1;
      3: b = st[k] + ln[k];
      4: b = st[k] + int'($urandom_range(0, ln[k] - 1));
      default: b = int'($urandom_range(0, 16'hFFFF));
    endcase
    return 16'(b);
  endfunction

  initial begin
    logic [15:0] a;
    rst = 1'b1; REQ = 1'b0; MAB = '0; MDBwrite = '0; MW = 1'b0; BW = 1'b0;
    CLR_FLAGS = 1'b0; RD_BUS = '0;
    repeat (3) @(negedge MCLK);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge MCLK);

    xact(16'h1C02, 1'b0, 1'b0, 16'h0000, {16'h1111, 16'h2222, 16'hA55A}, 1'b0);
    xact(16'h4401, 1'b0, 1'b1, 16'h0000, {16'h1111, 16'h12AB, 16'h3333}, 1'b0);
    xact(16'h1C05, 1'b1, 1'b1, 16'h00CD, 48'h0, 1'b0);
    xact(16'hFFFE, 1'b1, 1'b0, 16'hBEEF, 48'h0, 1'b0);
    xact(16'h0800, 1'b0, 1'b0, 16'h0000, 48'h0, 1'b1);
    xact(16'h0801, 1'b0, 1'b1, 16'h0000, 48'h0, 1'b1);

    // reset pulsed mid-access while REQ for the next access is already high
    issue(16'h4400, 1'b0, 1'b0, 16'h0, {16'h0, 16'h5678, 16'h0}, 1'b0);
    @(posedge MCLK); #1;
    @(negedge MCLK);
    rst = 1'b1;
    @(negedge MCLK);
    vma_m = 1'b0; acc_m = 1'b0;
    chk_reset("midrst");
    issue(16'h1C10, 1'b0, 1'b0, 16'h0, {16'h0, 16'h0, 16'h9ABC}, 1'b0);
    @(negedge MCLK);
    chk("midrst_ready2", 32'(READY), 32'd0);
    rst = 1'b0;
    serve(16'h1C10, 1'b0, 1'b0, 16'h0, {16'h0, 16'h0, 16'h9ABC}, 1'b0);

    for (int i = 0; i < 80; i++) begin
      a = pick_addr();
      xact(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           {16'($urandom), 16'($urandom), 16'($urandom)}, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
